// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared defaults, sample type and state encoding for the OFDM cyclic-prefix stripper
//
// Purpose: common definitions imported by ofdm_cp_strip.
//   NFFT_DEF / NCP_DEF / W_DEF : default symbol geometry and sample width
//   sample_t                   : complex sample at the default width
//   state_t                    : stripper FSM states
//   max_int                    : elaboration-time helper for counter sizing
package ofdm_pkg;

    localparam int NFFT_DEF = 128;
    localparam int NCP_DEF  = 16;
    localparam int W_DEF    = 17;

    typedef struct packed {
        logic signed [W_DEF-1:0] re;
        logic signed [W_DEF-1:0] im;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ofdm_cp_strip.sv
// rtl/ofdm_cp_strip.sv - removes the cyclic prefix from each OFDM symbol and forwards the useful samples
//
// Purpose: per symbol, drop NCP prefix samples and forward the next NFFT samples with one cycle latency.
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous active-low reset
//   InValid    in   input sample strobe
//   InSymStart in   first CP sample of a symbol (qualified by InValid)
//   InR, InI   in   W-bit signed sample components
//   Pushin     out  forwarded-sample strobe
//   FirstData  out  first forwarded sample of a symbol
//   DinR, DinI out  forwarded sample, held between pushes
//   SymErr     out  one-cycle pulse when a symbol is restarted mid-flight
//   SymCount   out  completed-symbol counter, wraps at 16 bits
module ofdm_cp_strip
    import ofdm_pkg::*;
#(
    parameter int NFFT = NFFT_DEF,
    parameter int NCP  = NCP_DEF,
    parameter int W    = W_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         InValid,
    input  logic         InSymStart,
    input  logic [W-1:0] InR,
    input  logic [W-1:0] InI,
    output logic         Pushin,
    output logic         FirstData,
    output logic [W-1:0] DinR,
    output logic [W-1:0] DinI,
    output logic         SymErr,
    output logic [15:0]  SymCount
);

    localparam int CW = $clog2(max_int(NFFT, NCP) + 1);

    localparam logic [CW-1:0] C_ZERO      = '0;
    localparam logic [CW-1:0] C_ONE       = CW'(1);
    localparam logic [CW-1:0] C_CP_LAST   = CW'(NCP - 1);
    localparam logic [CW-1:0] C_DATA_LAST = CW'(NFFT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_push;
    logic          w_first;
    logic          w_err;
    logic          w_done;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= C_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // In CP the counter holds the number of prefix samples already consumed;
    // in DATA it holds the index of the next useful sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_first     = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        if (InValid) begin
            if (InSymStart) begin
                // A start marker always begins a fresh symbol; outside IDLE the
                // symbol in flight is abandoned and flagged.
                w_err = (r_state != ST_IDLE);
                if (NCP == 0) begin
                    w_push  = 1'b1;
                    w_first = 1'b1;
                    if (NFFT == 1) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = C_ZERO;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = C_ONE;
                    end
                end else if (NCP == 1) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = C_ZERO;
                end else begin
                    w_state_nxt = ST_CP;
                    w_cnt_nxt   = C_ONE;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_state_nxt = ST_IDLE;
                    end
                    ST_CP: begin
                        if (r_cnt == C_CP_LAST) begin
                            w_state_nxt = ST_DATA;
                            w_cnt_nxt   = C_ZERO;
                        end else begin
                            w_cnt_nxt = r_cnt + C_ONE;
                        end
                    end
                    ST_DATA: begin
                        w_push  = 1'b1;
                        w_first = (r_cnt == C_ZERO);
                        if (r_cnt == C_DATA_LAST) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = C_ZERO;
                        end else begin
                            w_cnt_nxt = r_cnt + C_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = C_ZERO;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Pushin    <= 1'b0;
            FirstData <= 1'b0;
            SymErr    <= 1'b0;
            DinR      <= '0;
            DinI      <= '0;
            SymCount  <= 16'd0;
        end else begin
            Pushin    <= w_push;
            FirstData <= w_first;
            SymErr    <= w_err;
            if (w_push) begin
                DinR <= InR;
                DinI <= InI;
            end
            if (w_done) begin
                SymCount <= SymCount + 16'd1;
            end
        end
    end

endmodule
